// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the instruction/data memory port arbiter.
// Both the top level and the priority sub-module import this package.
package mem_arb_pkg;

   localparam int ABUS_DEF       = 32;
   localparam int DBUS_DEF       = 32;
   localparam int RD_LAT_DEF     = 1;
   localparam int STARVE_MAX_DEF = 4;

   // Counter widths cover the legal parameter ranges (RD_LAT 1..4, STARVE_MAX 1..7).
   localparam int WAIT_W   = 2;
   localparam int STARVE_W = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      FETCH = 1'b0,
      DATA  = 1'b1
   } req_id_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner selection between the fetch and data requesters.
// Data normally wins; fetch wins once it has been passed over STARVE_MAX times in a row.
module mem_arb_priority
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    sample,
   input  logic    if_req,
   input  logic    d_req,
   output req_id_t winner,
   output logic    any_req
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic [STARVE_W-1:0] starve_cnt;

   always_comb begin
      any_req = if_req | d_req;
      winner  = FETCH;
      if (d_req && !(if_req && (starve_cnt == STARVE_LIM)))
         winner = DATA;
   end

   // Only grants made while fetch is waiting count toward starvation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt <= '0;
      end else if (sample && any_req) begin
         if (winner == FETCH)
            starve_cnt <= '0;
         else if (if_req && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a load/store port,
// one transaction in flight at a time, with fixed read latency.
//
// state | meaning
// IDLE  | no transaction; requests sampled every edge
// ISSUE | one cycle: latched address/data on the memory bus, gnt pulse
// WAIT  | read in flight, RD_LAT cycles counted down; data captured on the last one
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ABUS       = ABUS_DEF,
   parameter int DBUS       = DBUS_DEF,
   parameter int RD_LAT     = RD_LAT_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_req,
   input  logic [ABUS-1:0] if_addr,
   output logic            if_gnt,
   output logic            if_valid,
   output logic [DBUS-1:0] if_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [ABUS-1:0] d_addr,
   input  logic [DBUS-1:0] d_wdata,
   output logic            d_gnt,
   output logic            d_valid,
   output logic [DBUS-1:0] d_rdata,
   output logic [ABUS-1:0] mem_addr,
   output logic [DBUS-1:0] mem_wdata,
   output logic            mem_we,
   output logic            mem_re,
   input  logic [DBUS-1:0] mem_rdata,
   output logic            busy
);

   state_t              state;
   req_id_t             cur_id;
   req_id_t             winner;
   logic                any_req;
   logic [WAIT_W-1:0]   wait_cnt;

   mem_arb_priority #(
      .STARVE_MAX (STARVE_MAX)
   ) u_priority (
      .clk     (clk),
      .rst     (rst),
      .sample  (state == IDLE),
      .if_req  (if_req),
      .d_req   (d_req),
      .winner  (winner),
      .any_req (any_req)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cur_id    <= FETCH;
         wait_cnt  <= '0;
         if_gnt    <= 1'b0;
         if_valid  <= 1'b0;
         if_rdata  <= '0;
         d_gnt     <= 1'b0;
         d_valid   <= 1'b0;
         d_rdata   <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
      end else begin
         if_gnt   <= 1'b0;
         d_gnt    <= 1'b0;
         mem_re   <= 1'b0;
         mem_we   <= 1'b0;
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  state  <= ISSUE;
                  cur_id <= winner;
                  if (winner == DATA) begin
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     mem_we    <= d_we;
                     mem_re    <= ~d_we;
                     d_gnt     <= 1'b1;
                  end else begin
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_re    <= 1'b1;
                     if_gnt    <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               // mem_we is still high here only for stores, which need no read wait.
               wait_cnt <= WAIT_W'(RD_LAT - 1);
               state    <= mem_we ? IDLE : WAIT;
            end
            WAIT: begin
               if (wait_cnt == '0) begin
                  state <= IDLE;
                  if (cur_id == FETCH) begin
                     if_valid <= 1'b1;
                     if_rdata <= mem_rdata;
                  end else begin
                     d_valid <= 1'b1;
                     d_rdata <= mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
